// File: rtl/cdb_pkg.sv
// Shared CDB types: one broadcast entry (ROB tag, destination physical reg, data)
// plus the arbitration-mode encoding and pointer-width helper.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package cdb_pkg;

    typedef struct packed {
        logic [`ROB_SIZE_WIDTH-1:0]         tag;
        logic [`PHYSICAL_REG_NUM_WIDTH-1:0] phy_dst;
        logic [`REG_DATA_WIDTH-1:0]         data;
    } cdb_entry_t;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_e;

    // Round-robin pointer width; never narrower than one bit.
    function automatic int unsigned ptr_w(int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer/CDB bus bundle: per-producer valid/ready/payload, control, and the
// registered broadcast with its statistics counter.
interface cdb_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 32
);
    import cdb_pkg::*;

    logic                          flush;
    logic                          prio_mode;
    logic       [NUM_REQ-1:0]      req_valid;
    logic       [NUM_REQ-1:0]      req_ready;
    cdb_entry_t [NUM_REQ-1:0]      req_entry;
    logic                          cdb_valid;
    cdb_entry_t                    cdb_entry;
    logic       [CNT_WIDTH-1:0]    total_broadcasts;

    modport master (
        output flush, prio_mode, req_valid, req_entry,
        input  req_ready, cdb_valid, cdb_entry, total_broadcasts
    );

    modport slave (
        input  flush, prio_mode, req_valid, req_entry,
        output req_ready, cdb_valid, cdb_entry, total_broadcasts
    );
endinterface

// File: rtl/cdb_arbiter_rr.sv
// One-hot grant: first valid request scanning from ptr_i (round-robin) or
// from index 0 (fixed priority).
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               mode_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [PTR_W:0] idx;
    logic           found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit holds ptr+k before the modulo wrap.
            idx = ((mode_i == PRIO_FIXED) ? '0 : {1'b0, ptr_i}) + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_REQ))
                idx = idx - (PTR_W+1)'(NUM_REQ);
            if (!found && req_i[idx[PTR_W-1:0]]) begin
                gnt_o[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one producer per cycle and registers its
// payload onto the CDB one cycle later; keeps a saturating broadcast count.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    cdb_arbiter_if.slave bus
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   arb_gnt, gnt;
    logic [PTR_W-1:0]     gidx;
    logic                 xfer;
    cdb_entry_t           sel_entry;
    logic                 cdb_valid_q;
    cdb_entry_t           cdb_entry_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i  (bus.req_valid),
        .ptr_i  (rr_ptr_q),
        .mode_i (bus.prio_mode),
        .gnt_o  (arb_gnt)
    );

    // Grants are suppressed while held in reset or during a flush.
    assign gnt           = (reset || bus.flush) ? '0 : arb_gnt;
    assign xfer          = |(gnt & bus.req_valid);
    assign bus.req_ready = gnt;

    always_comb begin
        gidx      = '0;
        sel_entry = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gidx      = PTR_W'(i);
                sel_entry = bus.req_entry[i];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && (bus.prio_mode == PRIO_RR))
            rr_ptr_d = (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + PTR_W'(1);
        cnt_d = (xfer && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_entry_q <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            cdb_valid_q <= xfer;
            if (xfer)
                cdb_entry_q <= sel_entry;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.cdb_valid        = cdb_valid_q;
    assign bus.cdb_entry        = cdb_entry_q;
    assign bus.total_broadcasts = cnt_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of result producers (ALU/MEM/branch units) sharing the CDB; legal range 2..8.
REQ-002 Parameter CNT_WIDTH, default 32, width of the broadcast statistics counter.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  pipeline flush; discards the in-flight broadcast and blocks grants this cycle.
REQ-006 prio_mode  input  1  0 = round-robin, 1 = fixed priority (index 0 highest).
REQ-007 req_valid  input  NUM_REQ  per-producer result valid.
REQ-008 req_ready  output  NUM_REQ  per-producer grant; one-hot or zero.
REQ-009 req_entry  input  NUM_REQ x cdb_entry_t  per-producer payload: ROB tag (`ROB_SIZE_WIDTH`), dest physical reg (`PHYSICAL_REG_NUM_WIDTH`), data (`REG_DATA_WIDTH`).
REQ-010 cdb_valid  output  1  registered CDB broadcast valid.
REQ-011 cdb_entry  output  cdb_entry_t  registered CDB payload.
REQ-012 total_broadcasts  output  CNT_WIDTH  running count of CDB broadcasts.

Function
REQ-013 Handshake: a transfer from producer i occurs in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-014 req_ready is combinational from req_valid, rr_ptr, prio_mode and flush; it has no combinational path from req_entry.
REQ-015 At most one req_ready bit is 1 per cycle; req_ready[i]=1 only if req_valid[i]=1.
REQ-016 Round-robin mode: grant the first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
REQ-017 Fixed mode: grant the lowest valid index; rr_ptr does not change.
REQ-018 rr_ptr (clog2(NUM_REQ) bits) updates to (granted index + 1) mod NUM_REQ on a round-robin transfer, wrapping from NUM_REQ-1 to 0; otherwise it holds.
REQ-019 Latency: payload transferred in cycle N appears on cdb_entry with cdb_valid=1 in cycle N+1, for exactly one cycle.
REQ-020 No transfer in cycle N -> cdb_valid=0 in cycle N+1; cdb_entry holds its last value.
REQ-021 flush=1 forces req_ready=0 and cdb_valid=0 in the next cycle; rr_ptr holds.
REQ-022 A producer whose req_valid stays 1 without a grant holds its payload stable; the arbiter does not drop or reorder a pending request.
REQ-023 In round-robin mode, a continuously asserted request is granted within NUM_REQ cycles.
REQ-024 A prio_mode change takes effect on the same-cycle grant; rr_ptr is retained across mode changes.
REQ-025 total_broadcasts increments by 1 per transfer and saturates at all-ones.

Reset
REQ-026 reset=1 asynchronously sets cdb_valid=0, cdb_entry='0, rr_ptr=0 and total_broadcasts=0.
REQ-027 req_ready is 0 while reset is asserted.
REQ-028 A broadcast in flight when reset asserts is discarded.
REQ-029 The first grant after reset deassertion uses rr_ptr=0.

Structure
REQ-030 cdb_entry_t (tag, phy_dst, data) lives in the shared package cdb_pkg with the existing global width macros.
REQ-031 Grant logic is one sub-module, rr_arbiter (inputs: request vector, pointer, mode; output: one-hot grant).
REQ-032 The output register, pointer and counter reside in cdb_arbiter.

Verification
REQ-033 Scenario: req_valid=4'b1111 held, round-robin -> grants 0,1,2,3,0 on consecutive cycles; cdb_valid=1 every cycle from cycle 2; total_broadcasts=5 after 5 transfers.
REQ-034 Scenario: prio_mode=1, req_valid=4'b1010 -> grant 1 every cycle; producer 3 is never granted while producer 1 stays valid.
REQ-035 Scenario: rr_ptr=3, req_valid=4'b0001 -> grant 0 and rr_ptr=1 after the transfer (wrap-around).
REQ-036 Scenario: transfer tag=5, data=32'hDEAD in cycle N, flush=1 in cycle N+1 -> the tag=5 broadcast appears on CDB in N+1; no grant in N+1; cdb_valid=0 in N+2.
REQ-037 Scenario: reset asserted mid-stream between clock edges -> cdb_valid=0, total_broadcasts=0 and rr_ptr=0 immediately; after release, req_valid=4'b0100 is granted index 2.
REQ-038 Scenario: CNT_WIDTH=4 with 20 transfers -> total_broadcasts saturates at 4'hF.
